// File: rtl/perm_cost_eval_pkg.sv
// Shared types and constants for the permutation cost evaluator.
package perm_cost_eval_pkg;

  localparam int N_PERM = 8;
  localparam int JOB_W  = 3;

  typedef logic [JOB_W-1:0] job_t;

  // Worker w's job lives in element w (worker 0 / input A in the low bits).
  typedef logic [N_PERM-1:0][JOB_W-1:0] perm_t;

  typedef enum logic [2:0] {
    READ = 3'd0,
    ACC  = 3'd1,
    CMP  = 3'd2,
    NEXT = 3'd3,
    WAIT = 3'd4,
    DONE = 3'd5
  } state_t;

  localparam job_t LAST_IDX = job_t'(N_PERM - 1);

  // 0,1,2,...,7 for workers 0..7.
  localparam perm_t IDENTITY  = {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
  // 7,6,5,...,0 for workers 0..7: the final permutation in lexicographic order.
  localparam perm_t LAST_PERM = {3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};

endpackage

// File: rtl/perm_cost_eval_cost_accum.sv
// Cost accumulator plus running minimum and tie counter, driven by FSM strobes.
module perm_cost_eval_cost_accum #(
  parameter int COST_W = 7,
  parameter int SUM_W  = 10,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              add,
  input  logic              cmp,
  input  logic [COST_W-1:0] cost,
  output logic [SUM_W-1:0]  min_cost,
  output logic [CNT_W-1:0]  match_count
);

  logic [SUM_W-1:0] acc;

  // Sum the eight ROM entries of the permutation under evaluation.
  // NOTE: sequential state is always assigned with <= so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (add) begin
      acc <= acc + SUM_W'(cost);
    end
  end

  // Replace the minimum on a strictly smaller total; count every total equal to it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      min_cost    <= '1;
      match_count <= '0;
    end else if (cmp) begin
      if (acc < min_cost) begin
        min_cost    <= acc;
        match_count <= CNT_W'(1);
      end else if (acc == min_cost) begin
        match_count <= match_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/perm_cost_eval.sv
// Evaluates every permutation from the generator against a cost ROM and
// reports the minimum total cost and how many permutations reach it.
module perm_cost_eval
  import perm_cost_eval_pkg::*;
#(
  parameter int COST_W = 7,
  parameter int SUM_W  = 10,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              perm_valid,
  input  logic [JOB_W-1:0]  A,
  input  logic [JOB_W-1:0]  B,
  input  logic [JOB_W-1:0]  C,
  input  logic [JOB_W-1:0]  D,
  input  logic [JOB_W-1:0]  E,
  input  logic [JOB_W-1:0]  F,
  input  logic [JOB_W-1:0]  G,
  input  logic [JOB_W-1:0]  H,
  output logic              next,
  output logic              cost_rd,
  output logic [JOB_W-1:0]  W,
  output logic [JOB_W-1:0]  J,
  input  logic [COST_W-1:0] Cost,
  output logic [SUM_W-1:0]  MinCost,
  output logic [CNT_W-1:0]  MatchCount,
  output logic              Valid
);

  state_t state_q, state_d;
  job_t   idx_q, idx_d;
  perm_t  snap_q, snap_d;

  logic acc_clr, acc_add, acc_cmp;

  // Next-state logic: walk the 8 reads, settle the last one, compare, then
  // request and wait for the following permutation.
  // NOTE: every variable gets a default before the case so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    snap_d  = snap_q;
    case (state_q)
      READ: begin
        // cost_rd is low in READ only on the first cycle after reset; that
        // cycle issues read 0 of the identity without advancing idx.
        if (cost_rd) begin
          if (idx_q == LAST_IDX) begin
            state_d = ACC;
          end else begin
            idx_d = idx_q + job_t'(1);
          end
        end
      end
      ACC:  state_d = CMP;
      CMP:  state_d = (snap_q == LAST_PERM) ? DONE : NEXT;
      NEXT: state_d = WAIT;
      WAIT: begin
        if (perm_valid) begin
          snap_d  = {H, G, F, E, D, C, B, A};
          idx_d   = '0;
          state_d = READ;
        end
      end
      DONE:    state_d = DONE;
      default: state_d = READ;
    endcase
  end

  // State, snapshot and outputs; outputs are decoded from the next state so
  // that each registered output lines up with the state it belongs to.
  // NOTE: the snapshot register array is reset on purpose: the identity is evaluated straight from it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= READ;
      idx_q   <= '0;
      snap_q  <= IDENTITY;
      next    <= 1'b0;
      cost_rd <= 1'b0;
      W       <= '0;
      J       <= '0;
      Valid   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
      next    <= (state_d == NEXT);
      cost_rd <= (state_d == READ);
      W       <= (state_d == READ) ? idx_d : '0;
      J       <= (state_d == READ) ? snap_d[idx_d] : '0;
      Valid   <= (state_d == DONE);
    end
  end

  // Cost of read k arrives during READ idx k+1 (read 7 during ACC).
  assign acc_clr = (state_q == READ) && (idx_q == '0);
  assign acc_add = ((state_q == READ) && (idx_q != '0)) || (state_q == ACC);
  assign acc_cmp = (state_q == CMP);

  perm_cost_eval_cost_accum #(
    .COST_W (COST_W),
    .SUM_W  (SUM_W),
    .CNT_W  (CNT_W)
  ) u_cost_accum (
    .clk         (clk),
    .reset       (reset),
    .clr         (acc_clr),
    .add         (acc_add),
    .cmp         (acc_cmp),
    .cost        (Cost),
    .min_cost    (MinCost),
    .match_count (MatchCount)
  );

endmodule

// File: tb/tb_perm_cost_eval.sv
// Bench for perm_cost_eval: a lexicographic generator model that presents a
// ranked subset of permutations (always ending with 7..0), a synchronous ROM
// model, a protocol monitor and a brute-force min/tie reference model.
module tb_perm_cost_eval;

  localparam int COST_W = 7;
  localparam int SUM_W  = 10;
  localparam int CNT_W  = 16;
  localparam int LAST_RANK = 40319;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              perm_valid = 1'b0;
  logic [2:0]        A, B, C, D, E, F, G, H;
  logic              next, cost_rd, Valid;
  logic [2:0]        W, J;
  logic [COST_W-1:0] Cost = '0;
  logic [SUM_W-1:0]  MinCost;
  logic [CNT_W-1:0]  MatchCount;

  always #5 clk = ~clk;

  perm_cost_eval #(.COST_W(COST_W), .SUM_W(SUM_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .perm_valid(perm_valid),
    .A(A), .B(B), .C(C), .D(D), .E(E), .F(F), .G(G), .H(H),
    .next(next), .cost_rd(cost_rd), .W(W), .J(J), .Cost(Cost),
    .MinCost(MinCost), .MatchCount(MatchCount), .Valid(Valid)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cost_tab [8][8];
  bit          rom_x_mode = 1'b0;
  int          seq [$];        // ranks the generator presents after the identity
  logic [23:0] exp_perms [$];  // every permutation expected to be evaluated, in order
  int          gen_k, busy;
  logic        s_next, s_rd;
  logic [2:0]  s_w, s_j;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Lexicographic rank -> permutation, worker 0 in bits 2:0.
  function automatic logic [23:0] unrank(input int rank);
    int avail [8];
    int n_av = 8;
    int r = rank;
    int f, d;
    logic [23:0] p = '0;
    for (int i = 0; i < 8; i++) avail[i] = i;
    for (int i = 0; i < 8; i++) begin
      f = 1;
      for (int k = 2; k <= 7 - i; k++) f *= k;
      d = r / f;
      r = r % f;
      p[i*3 +: 3] = 3'(avail[d]);
      for (int k = d; k < n_av - 1; k++) avail[k] = avail[k+1];
      n_av--;
    end
    return p;
  endfunction

  function automatic int perm_cost(input logic [23:0] p);
    int s = 0;
    for (int w = 0; w < 8; w++) s += cost_tab[w][p[w*3 +: 3]];
    return s;
  endfunction

  // Generator and ROM models: sample DUT outputs at the edge, drive 1 ns later.
  always begin
    @(posedge clk or posedge reset);
    if (reset) begin
      perm_valid = 1'b0;
      {H, G, F, E, D, C, B, A} = unrank(0);
      gen_k = 0;
      busy  = 0;
    end else begin
      s_next = next;
      s_rd   = cost_rd;
      s_w    = W;
      s_j    = J;
      #1;
      if (s_rd) Cost = COST_W'(cost_tab[s_w][s_j]);
      else if (rom_x_mode) Cost = 'x;
      if (s_next) begin
        perm_valid = 1'b0;
        busy = int'($urandom_range(1, 4));
        {H, G, F, E, D, C, B, A} = 24'($urandom);
      end else if (busy > 0) begin
        busy--;
        if (busy == 0 && gen_k < seq.size()) begin
          {H, G, F, E, D, C, B, A} = unrank(seq[gen_k]);
          gen_k++;
          perm_valid = 1'b1;
        end else begin
          {H, G, F, E, D, C, B, A} = 24'($urandom);
        end
      end
    end
  end

  // Protocol monitor.
  int          pulses, run_idx, run_pos;
  logic        prev_next;
  logic [23:0] got;

  always @(negedge clk) begin
    if (reset) begin
      pulses = 0; run_idx = 0; run_pos = 0; prev_next = 1'b0; got = '0;
    end else begin
      check("min_known",   32'($isunknown(MinCost)), 0);
      check("count_known", 32'($isunknown(MatchCount)), 0);
      if (next) begin
        check("next_width", 32'(prev_next), 0);
        check("next_after_valid", 32'(Valid), 0);
        pulses++;
      end
      prev_next = next;
      if (cost_rd) begin
        check("rd_W", 32'(W), run_pos);
        if (run_pos < 8) got[run_pos*3 +: 3] = J;
        run_pos++;
      end else if (run_pos != 0) begin
        check("rd_len", run_pos, 8);
        if (run_idx < exp_perms.size()) check("rd_J_perm", 32'(got), 32'(exp_perms[run_idx]));
        else check("rd_extra_run", run_idx, exp_perms.size() - 1);
        run_idx++;
        run_pos = 0;
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_next"},    32'(next), 0);
    check({tag, "_cost_rd"}, 32'(cost_rd), 0);
    check({tag, "_W"},       32'(W), 0);
    check({tag, "_J"},       32'(J), 0);
    check({tag, "_Valid"},   32'(Valid), 0);
    check({tag, "_MinCost"}, 32'(MinCost), (1 << SUM_W) - 1);
    check({tag, "_MatchCount"}, 32'(MatchCount), 0);
  endtask

  // Hold reset, pick the permutation subset, release reset at a falling edge.
  task automatic begin_run();
    int p;
    reset = 1'b1;
    seq.delete();
    exp_perms.delete();
    for (int k = 1; k <= 10; k++) seq.push_back(k);
    p = 10;
    while (1) begin
      p += int'($urandom_range(300, 3000));
      if (p >= LAST_RANK - 19) break;
      seq.push_back(p);
    end
    for (int k = LAST_RANK - 19; k <= LAST_RANK; k++) seq.push_back(k);
    exp_perms.push_back(unrank(0));
    foreach (seq[i]) exp_perms.push_back(unrank(seq[i]));
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Wait (bounded) for completion, then compare with the reference model.
  task automatic finish_run(input string tag);
    int cyc = 0;
    int exp_min = 1 << 30;
    int exp_cnt = 0;
    int c;
    foreach (exp_perms[i]) begin
      c = perm_cost(exp_perms[i]);
      if (c < exp_min) begin exp_min = c; exp_cnt = 1; end
      else if (c == exp_min) exp_cnt++;
    end
    while (!Valid && cyc < 4000) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_valid"}, 32'(Valid), 1);
    check({tag, "_min"},   32'(MinCost), exp_min);
    check({tag, "_count"}, 32'(MatchCount), exp_cnt);
    repeat (6) @(negedge clk);
    check({tag, "_valid_held"}, 32'(Valid), 1);
    check({tag, "_pulses"}, pulses, seq.size());
    check({tag, "_runs"},   run_idx, exp_perms.size());
  endtask

  initial begin
    int cyc;
    #1 reset = 1'b1;
    #1 check_reset_vals("reset");

    foreach (cost_tab[w, j]) cost_tab[w][j] = 1;
    begin_run();
    finish_run("all_one");

    foreach (cost_tab[w, j]) cost_tab[w][j] = (j == w) ? 0 : 10;
    begin_run();
    finish_run("diag");

    foreach (cost_tab[w, j]) cost_tab[w][j] = (j == 7 - w) ? 0 : 20;
    begin_run();
    finish_run("anti_diag");

    foreach (cost_tab[w, j]) cost_tab[w][j] = int'($urandom_range(0, 127));
    begin_run();
    finish_run("rand_wide");

    foreach (cost_tab[w, j]) cost_tab[w][j] = int'($urandom_range(0, 3));
    begin_run();
    finish_run("rand_ties");

    foreach (cost_tab[w, j]) cost_tab[w][j] = 127;
    begin_run();
    finish_run("all_max");

    // Reset in the middle of a permutation's reads, then a clean rerun.
    foreach (cost_tab[w, j]) cost_tab[w][j] = 1;
    begin_run();
    cyc = 0;
    do begin
      @(negedge clk);
      #1;
      cyc++;
    end while (!(run_idx >= 30 && cost_rd) && cyc < 4000);
    check("mid_reset_in_read", 32'(cost_rd), 1);
    reset = 1'b1;
    #1 check_reset_vals("mid_reset");
    begin_run();
    finish_run("after_reset");

    // ROM data is X outside the cycle after each read.
    rom_x_mode = 1'b1;
    foreach (cost_tab[w, j]) cost_tab[w][j] = (j == w) ? 0 : 10;
    begin_run();
    finish_run("xrom_diag");
    rom_x_mode = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
